// File: rtl/display_arbiter_pkg.sv
// display_arbiter_pkg: shared FSM states, source indices and segment masks.
package display_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, SHOW} state_t;
  localparam logic [1:0] SRC_OUT  = 2'd0;
  localparam logic [1:0] SRC_PC   = 2'd1;
  localparam logic [1:0] SRC_BUS  = 2'd2;
  localparam logic [1:0] SRC_NONE = 2'd3;
  localparam logic [7:0] SEG_A   = 8'h01;
  localparam logic [7:0] SEG_B   = 8'h02;
  localparam logic [7:0] SEG_C   = 8'h04;
  localparam logic [7:0] SEG_D   = 8'h08;
  localparam logic [7:0] SEG_E   = 8'h10;
  localparam logic [7:0] SEG_F   = 8'h20;
  localparam logic [7:0] SEG_G   = 8'h40;
  localparam logic [7:0] SEG_DOT = 8'h80;
endpackage

// File: rtl/display_arbiter_seg_decoder.sv
// seg_decoder: hex nibble to active-high {dot,g,f,e,d,c,b,a} glyph.
module seg_decoder
  import display_arbiter_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);
  always_comb begin
    seg = '0;
    case (hex)
      4'h0: seg = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
      4'h1: seg = SEG_B | SEG_C;
      4'h2: seg = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
      4'h3: seg = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
      4'h4: seg = SEG_B | SEG_C | SEG_F | SEG_G;
      4'h5: seg = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
      4'h6: seg = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
      4'h7: seg = SEG_A | SEG_B | SEG_C;
      4'h8: seg = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
      4'h9: seg = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;
      4'hA: seg = SEG_A | SEG_B | SEG_C | SEG_E | SEG_F | SEG_G;
      4'hB: seg = SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
      4'hC: seg = SEG_A | SEG_D | SEG_E | SEG_F;
      4'hD: seg = SEG_B | SEG_C | SEG_D | SEG_E | SEG_G;
      4'hE: seg = SEG_A | SEG_D | SEG_E | SEG_F | SEG_G;
      4'hF: seg = SEG_A | SEG_E | SEG_F | SEG_G;
    endcase
  end
endmodule

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin owner of a 4-digit multiplexed 7-segment display.
module display_arbiter
  import display_arbiter_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int SLOT_TICKS = 256
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  output logic [2:0] grant,
  output logic [1:0] owner,
  output logic [7:0] segments,
  output logic [3:0] digit
);
  state_t      state, state_nx;
  logic [15:0] div_cnt, slot_cnt;
  logic [1:0]  scan_idx, last, s0, s1, winner;
  logic [7:0]  value, win_data, owner_data, dec_out, seg_pat;
  logic [3:0]  req4, nib;
  logic        tick, slot_end, win_ok, take;
  assign req4 = {1'b0, req};
  assign tick = div_cnt == 16'(SCAN_DIV - 1);
  assign slot_end = tick && slot_cnt == 16'(SLOT_TICKS - 1);
  // Search starts just after the last owner, so it only wins again when alone.
  assign s0 = last == 2'd2 ? 2'd0 : last + 2'd1;
  assign s1 = s0 == 2'd2 ? 2'd0 : s0 + 2'd1;
  assign win_ok = |req;
  assign winner = req4[s0] ? s0 : req4[s1] ? s1 : last;
  assign take = state == GRANT && win_ok;
  assign win_data = winner == SRC_OUT ? data0 : winner == SRC_PC ? data1 : data2;
  assign owner_data = owner == SRC_OUT ? data0 : owner == SRC_PC ? data1 : data2;
  always_comb begin
    state_nx = state == IDLE  ? (win_ok ? GRANT : IDLE) :
               state == GRANT ? ((win_ok || owner != SRC_NONE) ? SHOW : IDLE) :
               (slot_end && win_ok) ? GRANT : SHOW;
    grant = take ? 3'b001 << winner : 3'b000;
  end
  assign nib = scan_idx == 2'd0 ? value[3:0] : scan_idx == 2'd1 ? value[7:4] : {2'b00, owner};
  seg_decoder u_dec (.hex(nib), .seg(dec_out));
  assign seg_pat = (owner == SRC_NONE || scan_idx == 2'd2 || (scan_idx == 2'd1 && value[7:4] == 4'h0)) ? 8'h00 :
                   scan_idx == 2'd3 ? dec_out | SEG_DOT : dec_out;
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= SRC_NONE;
      last     <= SRC_BUS;
      digit    <= 4'b0001;
      scan_idx <= 2'd0;
      segments <= 8'hFF;
      div_cnt  <= '0;
      slot_cnt <= '0;
      value    <= '0;
    end else begin
      state    <= state_nx;
      div_cnt  <= tick ? 16'd0 : div_cnt + 16'd1;
      segments <= ~seg_pat;
      if (tick) begin
        digit    <= {digit[2:0], digit[3]};
        scan_idx <= scan_idx + 2'd1;
      end
      if (take) begin
        owner    <= winner;
        last     <= winner;
        value    <= win_data;
        slot_cnt <= '0;
      end else if (state == SHOW) begin
        if (req4[owner]) value <= owner_data;
        if (tick) slot_cnt <= slot_end ? 16'd0 : slot_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: randomized stimulus against a behavioural display/arbiter model.
module tb_display_arbiter;
  localparam int SD = 4;
  localparam int ST = 2;
  logic       sys_clk = 1'b0;
  logic       rst;
  logic [2:0] req, grant;
  logic [7:0] data0, data1, data2, segments;
  logic [1:0] owner;
  logic [3:0] digit;
  int n_cmp = 0, n_bad = 0, n_grant = 0;
  int m_state, m_owner, m_last, m_div, m_idx, m_slot, m_val, m_seg;
  logic [7:0] gly [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                           8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  display_arbiter #(.SCAN_DIV(SD), .SLOT_TICKS(ST)) dut (
    .sys_clk(sys_clk), .rst(rst), .req(req), .data0(data0), .data1(data1), .data2(data2),
    .grant(grant), .owner(owner), .segments(segments), .digit(digit));

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int dat(input int s);
    return s == 0 ? int'(data0) : s == 1 ? int'(data1) : int'(data2);
  endfunction

  function automatic int pick();
    for (int k = 1; k <= 3; k++)
      if (req[(m_last + k) % 3]) return (m_last + k) % 3;
    return -1;
  endfunction

  function automatic int pattern();
    if (m_owner == 3 || m_idx == 2) return 0;
    if (m_idx == 0) return int'(gly[m_val % 16]);
    if (m_idx == 1) return (m_val / 16 == 0) ? 0 : int'(gly[m_val / 16]);
    return int'(gly[m_owner]) | 8'h80;
  endfunction

  task automatic model_step();
    int w, nseg;
    bit tk;
    if (rst) begin
      m_state = 0; m_owner = 3; m_last = 2; m_div = 0; m_idx = 0;
      m_slot = 0; m_val = 0; m_seg = 8'hFF;
      return;
    end
    tk = m_div == SD - 1;
    nseg = (~pattern()) & 8'hFF;
    w = pick();
    case (m_state)
      0: if (req != 0) m_state = 1;
      1: if (w >= 0) begin
           m_owner = w; m_last = w; m_val = dat(w); m_slot = 0; m_state = 2;
         end else m_state = (m_owner == 3) ? 0 : 2;
      default: begin
        if (m_owner != 3 && req[m_owner]) m_val = dat(m_owner);
        if (tk) begin
          if (m_slot + 1 == ST) begin
            m_slot = 0;
            if (req != 0) m_state = 1;
          end else m_slot++;
        end
      end
    endcase
    m_seg = nseg;
    m_div = tk ? 0 : m_div + 1;
    if (tk) m_idx = (m_idx + 1) % 4;
  endtask

  task automatic step();
    int w, eg;
    #1;
    w = pick();
    eg = (m_state == 1 && w >= 0) ? (1 << w) : 0;
    if (grant != 0) n_grant++;
    chk("grant", grant, eg);
    chk("owner", owner, m_owner);
    chk("digit", digit, 1 << m_idx);
    chk("segments", segments, m_seg);
    model_step();
    @(negedge sys_clk);
  endtask

  initial begin
    rst = 1'b1; req = 3'b000; data0 = 8'h00; data1 = 8'h00; data2 = 8'h00;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    model_step();
    chk("reset_segments", segments, 8'hFF);
    chk("reset_digit", digit, 4'b0001);
    step();
    rst = 1'b0;
    repeat (20) step();
    req = 3'b001; data0 = 8'h3C;
    repeat (60) step();
    req = 3'b111; data1 = 8'h07; data2 = 8'h5A;
    repeat (80) step();
    data1 = 8'hA5;
    repeat (40) step();
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(15) == 0) req = 3'($urandom);
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(2))
          0: data0 = ($urandom_range(1) == 0) ? 8'($urandom_range(15)) : 8'($urandom);
          1: data1 = ($urandom_range(1) == 0) ? 8'($urandom_range(15)) : 8'($urandom);
          default: data2 = 8'($urandom);
        endcase
      end
      rst = (m_state == 1) ? ($urandom_range(7) == 0) : ($urandom_range(299) == 0);
      step();
    end
    chk("grants_seen", n_grant > 20, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
